// File: rtl/mips_cpu_harvard_run_monitor.sv
// -----------------------------------------------------------------------------
// mips_cpu_harvard_run_monitor
//   Watches a mips_cpu_harvard run from reset release to halt. It times the
//   run, counts data-bus reads and writes, latches the final $v0 value, and
//   flags three failures: start-up failure, timeout and read/write conflict.
//   FPGA and simulation builds both take their pass/fail result from here.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   0 WAIT_START | reset released, waiting up to START_LIMIT edges for active
//   1 RUNNING    | CPU active, bus strobes counted, timeout armed
//   2 DRAIN      | one settle cycle for CPU writeback before result capture
//   3 DONE       | clean halt, result valid, everything frozen until clear
//   4 FAIL       | nostart or timeout, everything frozen until clear
//
// Ports
//   clk             in   system clock, rising edge
//   reset           in   async active-high reset (shared with the CPU)
//   active          in   CPU active flag
//   register_v0     in   CPU $v0 value
//   data_read       in   CPU data-bus read strobe
//   data_write      in   CPU data-bus write strobe
//   clear           in   synchronous re-arm, honoured only in DONE/FAIL
//   state           out  current state (encoding as in the table above)
//   cycle_count     out  cycles spent in WAIT_START+RUNNING+DRAIN
//   rd_count        out  RUNNING cycles with data_read high
//   wr_count        out  RUNNING cycles with data_write high
//   result          out  register_v0 captured on the DRAIN exit edge
//   done            out  high while in DONE
//   err_nostart     out  sticky, active never rose in time
//   err_timeout     out  sticky, run exceeded TIMEOUT_CYCLES
//   err_rw_conflict out  sticky, read and write strobes high together
// -----------------------------------------------------------------------------
module mips_cpu_harvard_run_monitor #(
  parameter int TIMEOUT_CYCLES = 100,
  parameter int START_LIMIT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        active,
  input  logic [31:0] register_v0,
  input  logic        data_read,
  input  logic        data_write,
  input  logic        clear,
  output logic [2:0]  state,
  output logic [31:0] cycle_count,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] result,
  output logic        done,
  output logic        err_nostart,
  output logic        err_timeout,
  output logic        err_rw_conflict
);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  localparam logic [31:0] START_LAST = 32'(START_LIMIT - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cycle_count;
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;
  logic [31:0] r_run_idx;
  logic [31:0] r_result;
  logic        r_done;
  logic        r_err_nostart;
  logic        r_err_timeout;
  logic        r_err_rw_conflict;

  logic w_start_expired;
  logic w_run_expired;
  logic w_count_cycle;
  logic w_in_run;
  logic w_rearm;
  logic w_set_nostart;
  logic w_set_timeout;
  logic w_set_conflict;
  logic w_latch_result;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  assign w_start_expired = (r_cycle_count == START_LAST);
  assign w_run_expired   = (r_run_idx == TO_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_WAIT;
    else       r_state <= w_next;
  end

  // Next-state logic. Halt is checked before timeout so it wins on a shared edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT: begin
        if (active)               w_next = S_RUN;
        else if (w_start_expired) w_next = S_FAIL;
      end
      S_RUN: begin
        if (!active)            w_next = S_DRAIN;
        else if (w_run_expired) w_next = S_FAIL;
      end
      S_DRAIN:        w_next = S_DONE;
      S_DONE, S_FAIL: if (clear) w_next = S_WAIT;
      default:        w_next = S_WAIT;
    endcase
  end

  // Per-state control strobes for the datapath registers
  always_comb begin
    w_count_cycle  = 1'b0;
    w_in_run       = 1'b0;
    w_rearm        = 1'b0;
    w_set_nostart  = 1'b0;
    w_set_timeout  = 1'b0;
    w_set_conflict = 1'b0;
    w_latch_result = 1'b0;
    case (r_state)
      S_WAIT: begin
        w_count_cycle = 1'b1;
        w_set_nostart = !active && w_start_expired;
      end
      S_RUN: begin
        w_count_cycle  = 1'b1;
        w_in_run       = 1'b1;
        w_set_timeout  = active && w_run_expired;
        w_set_conflict = data_read && data_write;
      end
      S_DRAIN: begin
        w_count_cycle  = 1'b1;
        w_latch_result = 1'b1;
      end
      S_DONE, S_FAIL: w_rearm = clear;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count     <= '0;
      r_rd_count        <= '0;
      r_wr_count        <= '0;
      r_run_idx         <= '0;
      r_result          <= '0;
      r_done            <= 1'b0;
      r_err_nostart     <= 1'b0;
      r_err_timeout     <= 1'b0;
      r_err_rw_conflict <= 1'b0;
    end else if (w_rearm) begin
      r_cycle_count     <= '0;
      r_rd_count        <= '0;
      r_wr_count        <= '0;
      r_run_idx         <= '0;
      r_result          <= '0;
      r_done            <= 1'b0;
      r_err_nostart     <= 1'b0;
      r_err_timeout     <= 1'b0;
      r_err_rw_conflict <= 1'b0;
    end else begin
      r_cycle_count <= sat_inc(r_cycle_count, w_count_cycle);
      r_rd_count    <= sat_inc(r_rd_count, w_in_run && data_read);
      r_wr_count    <= sat_inc(r_wr_count, w_in_run && data_write);
      // Held at zero while waiting so it is clear on RUNNING entry.
      if (r_state == S_WAIT) r_run_idx <= '0;
      else                   r_run_idx <= sat_inc(r_run_idx, w_in_run);
      if (w_latch_result) r_result <= register_v0;
      r_done            <= (w_next == S_DONE);
      r_err_nostart     <= r_err_nostart | w_set_nostart;
      r_err_timeout     <= r_err_timeout | w_set_timeout;
      r_err_rw_conflict <= r_err_rw_conflict | w_set_conflict;
    end
  end

  assign state           = r_state;
  assign cycle_count     = r_cycle_count;
  assign rd_count        = r_rd_count;
  assign wr_count        = r_wr_count;
  assign result          = r_result;
  assign done            = r_done;
  assign err_nostart     = r_err_nostart;
  assign err_timeout     = r_err_timeout;
  assign err_rw_conflict = r_err_rw_conflict;

endmodule

// File: tb/tb_mips_cpu_harvard_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_harvard_run_monitor
//   Directed bench for the run monitor, built with TIMEOUT_CYCLES=20 and
//   START_LIMIT=2. Inputs change 1 time unit after a rising edge, and outputs
//   are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_mips_cpu_harvard_run_monitor;

  logic        clk;
  logic        reset;
  logic        active;
  logic [31:0] register_v0;
  logic        data_read;
  logic        data_write;
  logic        clear;
  logic [2:0]  state;
  logic [31:0] cycle_count;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic [31:0] result;
  logic        done;
  logic        err_nostart;
  logic        err_timeout;
  logic        err_rw_conflict;

  int checks = 0;
  int errors = 0;

  mips_cpu_harvard_run_monitor #(
    .TIMEOUT_CYCLES(20),
    .START_LIMIT   (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .register_v0    (register_v0),
    .data_read      (data_read),
    .data_write     (data_write),
    .clear          (clear),
    .state          (state),
    .cycle_count    (cycle_count),
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .result         (result),
    .done           (done),
    .err_nostart    (err_nostart),
    .err_timeout    (err_timeout),
    .err_rw_conflict(err_rw_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge and release just after it; the next edge is edge 1.
  task automatic do_reset();
    reset = 1'b1; active = 1'b0; data_read = 1'b0; data_write = 1'b0;
    clear = 1'b0; register_v0 = '0;
    tick();
    reset = 1'b0;
  endtask

  // Edge 1 sees active (WAIT->RUN), edges 2..10 run with active high,
  // edge 11 sees active low (RUN->DRAIN), and edge 12 exits DRAIN.
  task automatic drive_run(input logic [31:0] v0);
    register_v0 = v0;
    active = 1'b1;
    repeat (10) tick();
    active = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; active = 1'b0; data_read = 1'b0; data_write = 1'b0;
    clear = 1'b0; register_v0 = 32'hDEAD_BEEF;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d exp 0", cycle_count); end
    checks++; if ({done, err_nostart, err_timeout, err_rw_conflict} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {done, err_nostart, err_timeout, err_rw_conflict}); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %0h exp 0", result); end
    reset = 1'b0;
  endtask

  task automatic test_clean_run();
    do_reset();
    register_v0 = 32'h0000_1234;
    active = 1'b1;
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL run_enter: got %0d exp 1", state); end
    repeat (9) tick();
    active = 1'b0;
    tick();
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL run_drain: got %0d exp 2", state); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_done_early: got %b exp 0", done); end
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL run_state: got %0d exp 3", state); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done: got %b exp 1", done); end
    checks++; if (result !== 32'h0000_1234) begin errors++; $display("FAIL run_result: got %0h exp 1234", result); end
    checks++; if (cycle_count !== 32'd12) begin errors++; $display("FAIL run_cycles: got %0d exp 12", cycle_count); end
    checks++; if ({err_nostart, err_timeout, err_rw_conflict} !== 3'b0) begin errors++; $display("FAIL run_errs: got %b exp 000", {err_nostart, err_timeout, err_rw_conflict}); end
    register_v0 = 32'h5555_5555;
    repeat (3) tick();
    checks++; if (cycle_count !== 32'd12 || result !== 32'h0000_1234 || done !== 1'b1) begin errors++; $display("FAIL run_frozen: got cyc %0d res %0h done %b exp 12 1234 1", cycle_count, result, done); end
  endtask

  task automatic test_timeout();
    do_reset();
    active = 1'b1;
    tick();
    repeat (19) tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL to_still_running: got %0d exp 1", state); end
    tick();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL to_state: got %0d exp 4", state); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b exp 1", err_timeout); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_done: got %b exp 0", done); end
    checks++; if (cycle_count !== 32'd21) begin errors++; $display("FAIL to_cycles: got %0d exp 21", cycle_count); end
    data_read = 1'b1;
    repeat (5) tick();
    data_read = 1'b0;
    checks++; if (cycle_count !== 32'd21 || rd_count !== 32'd0 || state !== 3'd4) begin errors++; $display("FAIL to_frozen: got cyc %0d rd %0d st %0d exp 21 0 4", cycle_count, rd_count, state); end
    active = 1'b0;
  endtask

  task automatic test_nostart();
    do_reset();
    tick();
    checks++; if (state !== 3'd0 || cycle_count !== 32'd1) begin errors++; $display("FAIL ns_edge1: got st %0d cyc %0d exp 0 1", state, cycle_count); end
    tick();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL ns_state: got %0d exp 4", state); end
    checks++; if (err_nostart !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL ns_flags: got ns %b to %b exp 1 0", err_nostart, err_timeout); end
    tick();
    checks++; if (cycle_count !== 32'd2) begin errors++; $display("FAIL ns_frozen: got %0d exp 2", cycle_count); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (state !== 3'd0 || err_nostart !== 1'b0 || cycle_count !== 32'd0) begin errors++; $display("FAIL ns_clear: got st %0d ns %b cyc %0d exp 0 0 0", state, err_nostart, cycle_count); end
  endtask

  task automatic test_bus_counts();
    logic [1:0] rw [7];
    rw[0] = 2'b10; rw[1] = 2'b10; rw[2] = 2'b10; rw[3] = 2'b01;
    rw[4] = 2'b01; rw[5] = 2'b11; rw[6] = 2'b00;
    do_reset();
    active = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      {data_read, data_write} = rw[i];
      tick();
      if (i == 5) begin
        checks++; if (err_rw_conflict !== 1'b1 || state !== 3'd1) begin errors++; $display("FAIL bus_conflict: got err %b st %0d exp 1 1", err_rw_conflict, state); end
      end
    end
    {data_read, data_write} = 2'b00;
    register_v0 = 32'hCAFE_0004;
    active = 1'b0;
    tick();
    // Strobes and a re-rising active in DRAIN must be ignored.
    active = 1'b1; data_read = 1'b1; data_write = 1'b1;
    tick();
    active = 1'b0; data_read = 1'b0; data_write = 1'b0;
    checks++; if (rd_count !== 32'd4) begin errors++; $display("FAIL bus_rd: got %0d exp 4", rd_count); end
    checks++; if (wr_count !== 32'd3) begin errors++; $display("FAIL bus_wr: got %0d exp 3", wr_count); end
    checks++; if (state !== 3'd3 || done !== 1'b1) begin errors++; $display("FAIL bus_done: got st %0d done %b exp 3 1", state, done); end
    checks++; if (result !== 32'hCAFE_0004) begin errors++; $display("FAIL bus_result: got %0h exp cafe0004", result); end
    checks++; if (cycle_count !== 32'd10) begin errors++; $display("FAIL bus_cycles: got %0d exp 10", cycle_count); end
    checks++; if (err_rw_conflict !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL bus_flags: got rw %b to %b exp 1 0", err_rw_conflict, err_timeout); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    active = 1'b1;
    tick();
    data_read = 1'b1;
    repeat (3) tick();
    data_read = 1'b0;
    checks++; if (rd_count !== 32'd3) begin errors++; $display("FAIL mr_pre_rd: got %0d exp 3", rd_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || cycle_count !== 32'd0 || rd_count !== 32'd0) begin errors++; $display("FAIL mr_async: got st %0d cyc %0d rd %0d exp 0 0 0", state, cycle_count, rd_count); end
    active = 1'b0;
    tick();
    reset = 1'b0;
    drive_run(32'h0000_5678);
    checks++; if (state !== 3'd3 || done !== 1'b1 || result !== 32'h0000_5678) begin errors++; $display("FAIL mr_rerun: got st %0d done %b res %0h exp 3 1 5678", state, done, result); end
    checks++; if (cycle_count !== 32'd12 || rd_count !== 32'd0) begin errors++; $display("FAIL mr_rerun_cnt: got cyc %0d rd %0d exp 12 0", cycle_count, rd_count); end
  endtask

  task automatic test_clear_and_halt_race();
    do_reset();
    register_v0 = 32'h0000_0099;
    active = 1'b1;
    tick();
    data_read = 1'b1; data_write = 1'b1;
    tick();
    data_read = 1'b0; data_write = 1'b0;
    active = 1'b0;
    tick();
    tick();
    checks++; if (state !== 3'd3 || err_rw_conflict !== 1'b1 || result !== 32'h99) begin errors++; $display("FAIL cl_pre: got st %0d rw %b res %0h exp 3 1 99", state, err_rw_conflict, result); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (state !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL cl_state: got st %0d done %b exp 0 0", state, done); end
    checks++; if ({cycle_count, rd_count, wr_count, result} !== 128'd0) begin errors++; $display("FAIL cl_zero: got cyc %0d rd %0d wr %0d res %0h exp all 0", cycle_count, rd_count, wr_count, result); end
    checks++; if (err_rw_conflict !== 1'b0) begin errors++; $display("FAIL cl_err: got %b exp 0", err_rw_conflict); end
    register_v0 = 32'h0000_0777;
    active = 1'b1;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (state !== 3'd1 || cycle_count !== 32'd2) begin errors++; $display("FAIL cl_in_run: got st %0d cyc %0d exp 1 2", state, cycle_count); end
    repeat (18) tick();
    active = 1'b0;
    tick();
    checks++; if (state !== 3'd2 || err_timeout !== 1'b0) begin errors++; $display("FAIL race_drain: got st %0d to %b exp 2 0", state, err_timeout); end
    tick();
    checks++; if (state !== 3'd3 || done !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL race_done: got st %0d done %b to %b exp 3 1 0", state, done, err_timeout); end
    checks++; if (cycle_count !== 32'd22 || result !== 32'h0000_0777) begin errors++; $display("FAIL race_cnt: got cyc %0d res %0h exp 22 777", cycle_count, result); end
  endtask

  initial begin
    reset = 1'b1; active = 1'b0; register_v0 = '0;
    data_read = 1'b0; data_write = 1'b0; clear = 1'b0;
    test_reset();
    test_clean_run();
    test_timeout();
    test_nostart();
    test_bus_counts();
    test_mid_reset();
    test_clear_and_halt_race();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
